// File: rtl/altivec_reset_sequencer.sv
// ---------------------------------------------------------------------------
// altivec_reset_sequencer
//
// Bring-up and soft-reset controller for the AltiVec core. After the platform
// reset drops, all unit resets are held for HOLD_CYCLES edges. They are then
// released one unit at a time in index order, STAGE_GAP edges apart. One edge
// after the last release, the core is declared ready and issue is ungated.
//
// A soft reset request seen in RUN is served in four steps:
//   1. Drain the pipeline. The drain ends at pipe_idle, or forcibly after
//      DRAIN_TIMEOUT edges.
//   2. Re-assert every unit reset for SOFT_HOLD edges.
//   3. Re-run the staggered release.
//   4. Pulse soft_rst_ack in the cycle in which core_ready rises.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   soft_rst_req  in   level request for a soft reset (honoured in RUN only)
//   pipe_idle     in   pipeline empty; sampled only while draining
//   unit_rst      out  per-unit active-high resets, released 0..NUM_UNITS-1
//   stall         out  blocks instruction issue
//   core_ready    out  core released and issuing
//   soft_rst_ack  out  one-cycle pulse when a soft reset completes
//   timeout_err   out  sticky: a drain timed out (cleared only by rst)
//
// Handshake: soft_rst_req is a level. It is accepted only in RUN while the
// request is armed. Acceptance disarms the request. It re-arms on any RUN
// edge that sees soft_rst_req low, so a request held high across its own ack
// starts no second soft reset.
// ---------------------------------------------------------------------------
module altivec_reset_sequencer #(
    parameter int NUM_UNITS     = 4,
    parameter int HOLD_CYCLES   = 4,
    parameter int STAGE_GAP     = 2,
    parameter int SOFT_HOLD     = 2,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 soft_rst_req,
    input  logic                 pipe_idle,
    output logic [NUM_UNITS-1:0] unit_rst,
    output logic                 stall,
    output logic                 core_ready,
    output logic                 soft_rst_ack,
    output logic                 timeout_err
);

    localparam int MAX_A  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_B  = (SOFT_HOLD > DRAIN_TIMEOUT) ? SOFT_HOLD : DRAIN_TIMEOUT;
    localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_C + 1);
    localparam int IDX_W  = $clog2(NUM_UNITS + 1);

    // Each wait ends on the edge where the counter already holds N-1, so the
    // transition happens on the N-th edge spent in the state.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_HOLD - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_DONE   = IDX_W'(NUM_UNITS);

    localparam logic [NUM_UNITS-1:0] ALL_ON  = {NUM_UNITS{1'b1}};
    localparam logic [NUM_UNITS-1:0] UNIT0   = NUM_UNITS'(1);

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_SOFT    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     rel_idx_q, rel_idx_d;   // next unit to release
    logic [NUM_UNITS-1:0] unit_rst_q, unit_rst_d;
    logic                 stall_q, stall_d;
    logic                 core_ready_q, core_ready_d;
    logic                 ack_q, ack_d;
    logic                 timeout_q, timeout_d;
    logic                 armed_q, armed_d;
    logic                 soft_q, soft_d;         // current release follows a soft reset

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rel_idx_d    = rel_idx_q;
        unit_rst_d   = unit_rst_q;
        stall_d      = stall_q;
        core_ready_d = core_ready_q;
        ack_d        = 1'b0;
        timeout_d    = timeout_q;
        armed_d      = armed_q;
        soft_d       = soft_q;

        case (state_q)
            ST_HOLD, ST_SOFT: begin
                if (cnt_q == ((state_q == ST_HOLD) ? HOLD_LAST : SOFT_LAST)) begin
                    unit_rst_d = ALL_ON & ~UNIT0;
                    rel_idx_d  = IDX_W'(1);
                    cnt_d      = '0;
                    state_d    = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (rel_idx_q == IDX_DONE) begin
                    // All units are out of reset: open issue one edge later.
                    state_d      = ST_RUN;
                    stall_d      = 1'b0;
                    core_ready_d = 1'b1;
                    ack_d        = soft_q;
                    soft_d       = 1'b0;
                    cnt_d        = '0;
                end else if (cnt_q == GAP_LAST) begin
                    unit_rst_d = unit_rst_q & ~(UNIT0 << rel_idx_q);
                    rel_idx_d  = rel_idx_q + IDX_W'(1);
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (soft_rst_req) begin
                    if (armed_q) begin
                        state_d      = ST_DRAIN;
                        stall_d      = 1'b1;
                        core_ready_d = 1'b0;
                        armed_d      = 1'b0;
                        soft_d       = 1'b1;
                        cnt_d        = '0;
                    end
                end else begin
                    armed_d = 1'b1;
                end
            end

            ST_DRAIN: begin
                // pipe_idle takes priority, so an idle pipe on the timeout
                // edge does not flag an error.
                if (pipe_idle || (cnt_q == DRAIN_LAST)) begin
                    state_d    = ST_SOFT;
                    unit_rst_d = ALL_ON;
                    cnt_d      = '0;
                    if (!pipe_idle) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            rel_idx_q    <= '0;
            unit_rst_q   <= ALL_ON;
            stall_q      <= 1'b1;
            core_ready_q <= 1'b0;
            ack_q        <= 1'b0;
            timeout_q    <= 1'b0;
            armed_q      <= 1'b1;
            soft_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rel_idx_q    <= rel_idx_d;
            unit_rst_q   <= unit_rst_d;
            stall_q      <= stall_d;
            core_ready_q <= core_ready_d;
            ack_q        <= ack_d;
            timeout_q    <= timeout_d;
            armed_q      <= armed_d;
            soft_q       <= soft_d;
        end
    end

    assign unit_rst     = unit_rst_q;
    assign stall        = stall_q;
    assign core_ready   = core_ready_q;
    assign soft_rst_ack = ack_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_altivec_reset_sequencer.sv
// Directed bench for altivec_reset_sequencer with default parameters.
// Each expectation is packed as {unit_rst, stall, core_ready, soft_rst_ack,
// timeout_err} and was worked out by hand from the intended timing.
module tb_altivec_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       soft_rst_req;
  logic       pipe_idle;
  logic [3:0] unit_rst;
  logic       stall;
  logic       core_ready;
  logic       soft_rst_ack;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  altivec_reset_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .pipe_idle    (pipe_idle),
    .unit_rst     (unit_rst),
    .stall        (stall),
    .core_ready   (core_ready),
    .soft_rst_ack (soft_rst_ack),
    .timeout_err  (timeout_err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] u, input logic s,
                          input logic r, input logic a, input logic t);
    chk(tag, {unit_rst, stall, core_ready, soft_rst_ack, timeout_err}, {u, s, r, a, t});
  endtask

  // Called just after the edge on which unit_rst became 1110. Walks the
  // staggered release up to the edge on which core_ready rises.
  task automatic release_seq(input string tag, input logic ack_exp, input logic to_exp);
    tick(); chk_outs({tag, "_r1"}, 4'b1110, 1'b1, 1'b0, 1'b0, to_exp);
    tick(); chk_outs({tag, "_r2"}, 4'b1100, 1'b1, 1'b0, 1'b0, to_exp);
    tick(); chk_outs({tag, "_r3"}, 4'b1100, 1'b1, 1'b0, 1'b0, to_exp);
    tick(); chk_outs({tag, "_r4"}, 4'b1000, 1'b1, 1'b0, 1'b0, to_exp);
    tick(); chk_outs({tag, "_r5"}, 4'b1000, 1'b1, 1'b0, 1'b0, to_exp);
    tick(); chk_outs({tag, "_r6"}, 4'b0000, 1'b1, 1'b0, 1'b0, to_exp);
    tick(); chk_outs({tag, "_run"}, 4'b0000, 1'b0, 1'b1, ack_exp, to_exp);
  endtask

  // From rst dropping: three HOLD edges, the first release, then the stagger.
  task automatic bring_up(input string tag, input logic to_exp);
    for (int k = 1; k <= 3; k++) begin
      tick(); chk_outs({tag, "_hold"}, 4'b1111, 1'b1, 1'b0, 1'b0, to_exp);
    end
    tick(); chk_outs({tag, "_e4"}, 4'b1110, 1'b1, 1'b0, 1'b0, to_exp);
    release_seq(tag, 1'b0, to_exp);
  endtask

  initial begin
    rst          = 1'b1;
    soft_rst_req = 1'b0;
    pipe_idle    = 1'b0;

    // Power-on with defaults
    tick(); tick(); tick();
    chk_outs("reset_state", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bring_up("poweron", 1'b0);
    tick(); chk_outs("poweron_run", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Soft reset with quick drain
    soft_rst_req = 1'b1;
    tick(); chk_outs("qd_drain", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    soft_rst_req = 1'b0;
    tick(); chk_outs("qd_drain2", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    pipe_idle = 1'b1;
    tick(); chk_outs("qd_soft1", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    pipe_idle = 1'b0;
    tick(); chk_outs("qd_soft2", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk_outs("qd_rel0", 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
    release_seq("qd", 1'b1, 1'b0);
    tick(); chk_outs("qd_ack_done", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Drain timeout: SOFT entered on the 64th DRAIN edge
    soft_rst_req = 1'b1;
    tick(); chk_outs("to_drain", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    soft_rst_req = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      tick(); chk_outs("to_waiting", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick(); chk_outs("to_soft1", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); chk_outs("to_soft2", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); chk_outs("to_rel0", 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1);
    release_seq("to", 1'b1, 1'b1);
    tick(); chk_outs("to_sticky", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Held request: exactly one soft reset until it drops
    soft_rst_req = 1'b1;
    tick(); chk_outs("held_drain", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    pipe_idle = 1'b1;
    tick(); chk_outs("held_soft1", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    pipe_idle = 1'b0;
    tick(); chk_outs("held_soft2", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); chk_outs("held_rel0", 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1);
    release_seq("held", 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(); chk_outs("held_no_retrigger", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    soft_rst_req = 1'b0;
    tick(); chk_outs("held_drop", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    soft_rst_req = 1'b1;
    tick(); chk_outs("held_second_drain", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    soft_rst_req = 1'b0;
    pipe_idle    = 1'b1;
    tick(); chk_outs("held2_soft1", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    pipe_idle = 1'b0;
    tick(); chk_outs("held2_soft2", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); chk_outs("held2_rel0", 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1);
    release_seq("held2", 1'b1, 1'b1);

    // Reset mid-operation: rst clears timeout_err
    rst = 1'b1;
    tick(); chk_outs("rst_clears_to", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(); chk_outs("mid_hold", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick(); chk_outs("mid_e4", 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk_outs("mid_e5", 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk_outs("mid_e6", 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); chk_outs("rst_in_release", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bring_up("after_rel_rst", 1'b0);
    soft_rst_req = 1'b1;
    tick(); chk_outs("mid_drain", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    soft_rst_req = 1'b0;
    tick(); chk_outs("mid_drain2", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); chk_outs("rst_in_drain", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);

    // Request outside RUN: held from HOLD, honoured after core_ready rises.
    // The bring-up also shows the abandoned soft reset yields no ack.
    rst          = 1'b0;
    soft_rst_req = 1'b1;
    bring_up("early_req", 1'b0);
    tick(); chk_outs("early_drain", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    soft_rst_req = 1'b0;
    pipe_idle    = 1'b1;
    tick(); chk_outs("early_soft1", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    pipe_idle = 1'b0;
    tick(); chk_outs("early_soft2", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk_outs("early_rel0", 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
    release_seq("early", 1'b1, 1'b0);
    tick(); chk_outs("early_done", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/altivec_reset_sequencer.md
Name: altivec_reset_sequencer

Overview:
- Bring-up and soft-reset controller for the AltiVec core.
- Takes the single platform reset and releases per-unit resets in a fixed staggered order (VRF, VALU, VPERM, LSU by default).
- Gates instruction issue until the core is ready.
- Serves soft-reset requests from the test harness: drains the pipeline, re-applies unit resets and re-runs the release sequence.

Parameters:
- NUM_UNITS, 4: number of unit reset outputs; released in index order 0..NUM_UNITS-1.
- HOLD_CYCLES, 4: cycles all unit resets stay asserted after rst deasserts (legal range ≥1).
- STAGE_GAP, 2: cycles between consecutive unit releases (legal range ≥1).
- SOFT_HOLD, 2: cycles all unit resets stay asserted during a soft reset (legal range ≥1).
- DRAIN_TIMEOUT, 64: maximum cycles waiting for pipe_idle before forcing the soft reset.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- soft_rst_req, input, 1: level request for soft reset.
- pipe_idle, input, 1: core pipeline empty, no outstanding LSU transactions.
- unit_rst, output, NUM_UNITS: per-unit synchronous active-high resets.
- stall, output, 1: blocks instruction issue.
- core_ready, output, 1: core released and issuing.
- soft_rst_ack, output, 1: one-cycle pulse when a soft reset completes.
- timeout_err, output, 1: sticky flag, drain timed out.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high; all outputs registered.
- Reset values (edge with rst=1): state=HOLD, cycle counter=0, unit_rst=all 1, stall=1, core_ready=0, soft_rst_ack=0, timeout_err=0, armed=1.
- States: HOLD, RELEASE, RUN, DRAIN, SOFT.
- HOLD: counter increments on each edge with rst=0. On the HOLD_CYCLES-th such edge, unit_rst[0] clears, counter resets, next state=RELEASE.
- RELEASE: unit_rst[i] clears STAGE_GAP edges after unit_rst[i-1]. On the edge after unit_rst[NUM_UNITS-1] clears, the block goes to RUN with stall=0 and core_ready=1.
- Default timing: unit_rst bits clear at edges 4, 6, 8, 10 after rst drop; core_ready rises at edge 11.
- A released unit_rst bit never re-asserts except via SOFT or rst.
- RUN: if soft_rst_req=1 and armed=1, the next edge sets state=DRAIN, stall=1, core_ready=0, armed=0, counter=0.
- DRAIN: unit_rst stays 0; counter increments each edge.
  - pipe_idle=1 on an edge → SOFT, unit_rst=all 1, counter=0.
  - Counter reaches DRAIN_TIMEOUT with pipe_idle still 0 → same transition as pipe_idle, and timeout_err is also set to 1.
  - If pipe_idle=1 on the timeout edge, no error is flagged.
- SOFT: holds for SOFT_HOLD edges. Then unit_rst[0] clears and the block enters RELEASE; HOLD_CYCLES is not repeated.
- Soft-reset completion: when RELEASE completes after a soft reset, soft_rst_ack=1 for exactly the one cycle in which core_ready rises. Initial bring-up never produces an ack.
- Re-arm: armed returns to 1 on any edge in RUN with soft_rst_req=0. A request held high across its own ack does not start a second soft reset; it must drop for at least one cycle first.
- soft_rst_req in HOLD, RELEASE, DRAIN or SOFT is ignored. If it is still high (and armed) once RUN is reached, it is honoured then.
- timeout_err is sticky; only rst clears it.
- rst=1 in any state overrides at that edge: all reset values apply, and an in-flight soft reset is abandoned with no ack.
- pipe_idle is sampled only in DRAIN.
- Counter width: clog2 of max(HOLD_CYCLES, STAGE_GAP, SOFT_HOLD, DRAIN_TIMEOUT)+1; it never wraps.

Test Plan:
- Power-on, defaults: rst high 3 cycles then low → unit_rst = 1111 until edge 4, then 1110@4, 1100@6, 1000@8, 0000@10; core_ready=1, stall=0 @11; soft_rst_ack never pulses.
- Soft reset with quick drain: in RUN, raise soft_rst_req; pipe_idle=1 two cycles later → stall=1 next edge; unit_rst=1111 for 2 edges; staggered release (gap 2); one-cycle ack coincident with core_ready rise; timeout_err=0.
- Drain timeout: soft_rst_req=1, pipe_idle held 0 → SOFT entered on the 64th DRAIN edge; timeout_err=1 and stays 1 through the completed sequence and later RUN.
- Held request: soft_rst_req held high through ack and 20 more cycles → exactly one soft reset. Drop for 1 cycle, raise again → second soft reset runs.
- Reset mid-operation: assert rst during RELEASE (after unit_rst=1100) and separately during DRAIN → next edge unit_rst=1111, core_ready=0, no ack; full HOLD sequence restarts from 0 and timeout_err clears.
- Request outside RUN: soft_rst_req=1 during initial HOLD → ignored until RUN, then DRAIN begins on the edge after core_ready rises.
